// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single synchronous-read memory port.
// Instruction fetch (IF) and load/store (LS) share the port; a grant is
// issued combinationally in the request cycle, conflicts are resolved
// round-robin, and a small return FSM steers the read data that arrives
// one cycle after each read grant back to the requester that issued it.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   conflict_cnt
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_LS} state_t;

  localparam logic LAST_IF = 1'b0;
  localparam logic LAST_LS = 1'b1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_gnt;
  logic [15:0] r_conflict_cnt;
  logic        w_if_gnt;
  logic        w_ls_gnt;
  logic        w_conflict;

  assign w_conflict = if_req & ls_req;

  // Grant: lone requester wins immediately; on conflict the side that did
  // not win last time goes. Reset input gates grants so nothing reaches
  // the memory while reset is held.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (reset) begin
      if (w_conflict) begin
        if (r_last_gnt == LAST_IF) w_ls_gnt = 1'b1;
        else                       w_if_gnt = 1'b1;
      end else begin
        w_if_gnt = if_req;
        w_ls_gnt = ls_req;
      end
    end
  end

  assign if_gnt = w_if_gnt;
  assign ls_gnt = w_ls_gnt;
  assign mem_en = w_if_gnt | w_ls_gnt;

  // Port mux: fetches are always reads with zero write data; idle port is all-zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_if_gnt) begin
      mem_addr = if_addr;
    end else if (w_ls_gnt) begin
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end
  end

  // Return FSM next state: remember which requester owns next cycle's read data.
  always_comb begin
    w_state_nxt = IDLE;
    if (w_if_gnt)                w_state_nxt = RD_IF;
    else if (w_ls_gnt && !ls_we) w_state_nxt = RD_LS;
  end

  // Return FSM state register; reset drops any read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Round-robin history; reset to IF so LS wins the first conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_last_gnt <= LAST_IF;
    else if (w_if_gnt) r_last_gnt <= LAST_IF;
    else if (w_ls_gnt) r_last_gnt <= LAST_LS;
  end

  // Saturating count of cycles in which both sides were requesting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_conflict_cnt <= '0;
    else if (w_conflict && (r_conflict_cnt != 16'hFFFF))
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign conflict_cnt = r_conflict_cnt;
  assign if_rvalid    = (r_state == RD_IF);
  assign ls_rvalid    = (r_state == RD_LS);
  assign if_rdata     = if_rvalid ? mem_rdata : '0;
  assign ls_rdata     = ls_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read memory.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   conflict_cnt;

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] mem [0:255];

  always #5 clk = ~clk;

  // Word-addressed memory, read data one cycle after a read access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h4;
    @(negedge clk);
    checks++; if ({if_gnt, ls_gnt, mem_en} !== 3'b000) $display("FAIL rst_gnt got %b want 000", {if_gnt, ls_gnt, mem_en}); else passed++;
    next_cycle(); @(negedge clk);
    checks++; if (conflict_cnt !== 16'd0) $display("FAIL rst_cnt got %0d want 0", conflict_cnt); else passed++;
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) $display("FAIL rst_rvalid got %b want 00", {if_rvalid, ls_rvalid}); else passed++;
    checks++; if ((if_rdata | ls_rdata) !== '0) $display("FAIL rst_rdata got %h/%h want 0", if_rdata, ls_rdata); else passed++;
    idle_inputs();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0; ls_wdata = 32'h12345678;
    @(negedge clk);
    checks++; if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b1010) $display("FAIL fetch_gnt got %b want 1010", {if_gnt, ls_gnt, mem_en, mem_we}); else passed++;
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL fetch_port got %h/%h want 0/0", mem_addr, mem_wdata); else passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h55555554) $display("FAIL fetch_rdata got %b/%h want 1/55555554", if_rvalid, if_rdata); else passed++;
    checks++; if (mem_en !== 1'b0 || mem_addr !== '0) $display("FAIL fetch_idle got %b/%h want 0/0", mem_en, mem_addr); else passed++;
    next_cycle();
  endtask

  task automatic test_store_load();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h4; ls_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if ({ls_gnt, mem_en, mem_we} !== 3'b111) $display("FAIL st_gnt got %b want 111", {ls_gnt, mem_en, mem_we}); else passed++;
    checks++; if (mem_addr !== 32'h4 || mem_wdata !== 32'hDEADBEEF) $display("FAIL st_port got %h/%h want 4/deadbeef", mem_addr, mem_wdata); else passed++;
    next_cycle();
    ls_we = 1'b0; ls_wdata = '0;
    @(negedge clk);
    checks++; if (ls_rvalid !== 1'b0) $display("FAIL st_norvalid got %b want 0", ls_rvalid); else passed++;
    checks++; if ({ls_gnt, mem_we} !== 2'b10) $display("FAIL ld_gnt got %b want 10", {ls_gnt, mem_we}); else passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hDEADBEEF) $display("FAIL ld_rdata got %b/%h want 1/deadbeef", ls_rvalid, ls_rdata); else passed++;
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== '0) $display("FAIL ld_if_quiet got %b/%h want 0/0", if_rvalid, if_rdata); else passed++;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) $display("FAIL b2b_if_gnt got %b want 1", if_gnt); else passed++;
    next_cycle();
    if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h4;
    @(negedge clk);
    checks++; if ({ls_gnt, if_rvalid} !== 2'b11 || if_rdata !== 32'h55555554) $display("FAIL b2b_overlap got %b/%h want 11/55555554", {ls_gnt, if_rvalid}, if_rdata); else passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hDEADBEEF) $display("FAIL b2b_ls_rdata got %b/%h want 1/deadbeef", ls_rvalid, ls_rdata); else passed++;
    next_cycle();
  endtask

  task automatic test_conflict();
    logic [3:0] exp_gnt;  // bit set = LS granted, cycles 0..3
    logic [3:0] exp_lsv;  // ls_rvalid expected per cycle 1..4
    logic [3:0] exp_ifv;
    exp_gnt = 4'b0101;
    exp_lsv = 4'b0101;
    exp_ifv = 4'b1010;
    reset = 1'b0; next_cycle(); reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_addr = 32'h4;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) idle_inputs();
      @(negedge clk);
      if (c < 4) begin
        checks++;
        if ({ls_gnt, if_gnt} !== {exp_gnt[c], ~exp_gnt[c]} || mem_addr !== (exp_gnt[c] ? 32'h4 : 32'h0))
          $display("FAIL conf_gnt%0d got ls=%b if=%b addr=%h want ls=%b", c, ls_gnt, if_gnt, mem_addr, exp_gnt[c]);
        else passed++;
      end
      if (c > 0) begin
        checks++;
        if ({ls_rvalid, if_rvalid} !== {exp_lsv[c-1], exp_ifv[c-1]} ||
            (ls_rvalid && ls_rdata !== 32'hDEADBEEF) || (if_rvalid && if_rdata !== 32'h55555554))
          $display("FAIL conf_rv%0d got ls=%b/%h if=%b/%h", c, ls_rvalid, ls_rdata, if_rvalid, if_rdata);
        else passed++;
      end
      next_cycle();
    end
    checks++; if (conflict_cnt !== 16'd4) $display("FAIL conf_cnt got %0d want 4", conflict_cnt); else passed++;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_en, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 5'b0)
        $display("FAIL idle%0d got %b want 00000", c, {mem_en, if_gnt, ls_gnt, if_rvalid, ls_rvalid});
      else passed++;
      next_cycle();
    end
    // last grant was IF, so LS must win this conflict
    if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h4;
    @(negedge clk);
    checks++; if ({ls_gnt, if_gnt} !== 2'b10) $display("FAIL idle_rr got %b want 10", {ls_gnt, if_gnt}); else passed++;
    next_cycle();
    idle_inputs();
    checks++; if (conflict_cnt !== 16'd5) $display("FAIL idle_cnt got %0d want 5", conflict_cnt); else passed++;
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) $display("FAIL mid_gnt got %b want 1", if_gnt); else passed++;
    #1 reset = 1'b0;
    #1;
    checks++; if ({if_gnt, mem_en} !== 2'b00) $display("FAIL mid_gate got %b want 00", {if_gnt, mem_en}); else passed++;
    next_cycle();
    checks++; if (if_rvalid !== 1'b0) $display("FAIL mid_rv_rst got %b want 0", if_rvalid); else passed++;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== '0) $display("FAIL mid_rv_rel got %b/%h want 0/0", if_rvalid, if_rdata); else passed++;
    checks++; if (conflict_cnt !== 16'd0) $display("FAIL mid_cnt got %0d want 0", conflict_cnt); else passed++;
    next_cycle();
  endtask

  task automatic test_saturation();
    if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h0; ls_addr = 32'h4;
    repeat (65534) next_cycle();
    checks++; if (conflict_cnt !== 16'hFFFE) $display("FAIL sat_pre got %h want fffe", conflict_cnt); else passed++;
    repeat (70000 - 65534) next_cycle();
    checks++; if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_cnt got %h want ffff", conflict_cnt); else passed++;
    repeat (10) next_cycle();
    checks++; if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", conflict_cnt); else passed++;
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 32'h55555554;
    idle_inputs();
    reset = 1'b0;
    #2;
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_conflict();
    test_idle();
    test_reset_mid_read();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
